spi_frame_loader: RTL and testbench
===================================

// Module: spi_frame_loader
// PURPOSE
// - Consumes the received-byte stream from the EFB SPI-slave Wishbone controller (one strobe per RXD read).
// - Parses a command-framed transaction and writes pixel bytes into the HUB75 framebuffer RAM.
// - Owns the global brightness register, which drives the PWM/scan stage.
// - Flips the display bank when a complete frame has been loaded.
// PARAMETERS
// ADDR_W      11     framebuffer address width
// FB_DEPTH    2048   number of valid framebuffer bytes (<= 2**ADDR_W)
// CMD_WRITE   8'hA0  opcode: framebuffer write
// CMD_BRIGHT  8'hB0  opcode: set brightness
// DRAIN_CYC   16     clk_96m cycles to wait after CS release before closing the transaction
// PORTS
// clk_96m     in   1       system clock
// nrst        in   1       asynchronous active-low reset
// rx_valid    in   1       one-cycle strobe: rx_data holds a received SPI byte
// rx_data     in   8       received byte
// spi_scsn    in   1       raw SPI chip select pin, active low, asynchronous
// fb_we       out  1       framebuffer write enable, one cycle per byte
// fb_addr     out  ADDR_W  framebuffer write address
// fb_wdata    out  8       framebuffer write data
// fb_bank     out  1       bank currently being displayed; toggles on frame_done
// brightness  out  8       global brightness for the PWM stage
// frame_done  out  1       one-cycle pulse when a write transaction closes
// overflow    out  1       sticky: data was dropped because the address is beyond FB_DEPTH-1
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low. Clock port clk_96m, reset port nrst.
// - Reset values:
//   - all outputs 0.
//   - state = S_CMD; address counter, write count and drain counter are 0.
//   - scsn synchroniser flops reset to 1.
// - spi_scsn passes through a 2-flop synchroniser (scsn_s).
// - A 0->1 edge of scsn_s loads drain_cnt = DRAIN_CYC.
//   - Each cycle: if rx_valid, drain_cnt reloads to DRAIN_CYC; otherwise it decrements toward 0.
//   - The transaction ends in the cycle drain_cnt goes 1->0 (late RXD reads still land in the current transaction).
// - States:
//   - S_CMD: byte == CMD_WRITE -> S_ADDR_H and clear overflow; byte == CMD_BRIGHT -> S_BRIGHT; any other byte -> S_SKIP.
//   - S_ADDR_H: byte -> addr[ADDR_W-1:8] (upper byte bits beyond ADDR_W ignored) -> S_ADDR_L.
//   - S_ADDR_L: byte -> addr[7:0]; wr_count = 0 -> S_DATA.
//   - S_DATA: each byte is written to the framebuffer (write path below).
//   - S_BRIGHT: byte -> brightness -> S_SKIP.
//   - S_SKIP: all bytes ignored.
//   - Every state -> S_CMD at transaction end; no state advances without rx_valid.
// - Write path (S_DATA):
//   - rx_valid in cycle n -> fb_we = 1 in cycle n+1, with fb_addr = current addr and fb_wdata = the byte; then addr+1 and wr_count+1.
//   - If addr >= FB_DEPTH: no write, overflow <= 1, addr holds (no wrap).
//   - Back-to-back rx_valid is supported: one write per cycle, latency 1.
// - Transaction end:
//   - If state == S_DATA and wr_count > 0: frame_done pulses for 1 cycle, fb_bank toggles in the same cycle.
//   - An end from any other state, or with wr_count == 0: no pulse, no toggle.
// - Simultaneous events:
//   - rx_valid in the same cycle as the scsn_s rising edge: the byte is processed, and drain starts.
//   - A new scsn_s falling edge while draining: drain aborts (drain_cnt = 0), no end occurs, and the transaction continues.
// - Reset mid-transaction:
//   - immediate return to reset values.
//   - no frame_done; brightness returns to 0; an fb_we in flight is dropped.
// TESTING
// 1. CS low; bytes A0,00,10,11,22,33; CS high -> fb_we x3 at addr 0x010..0x012 with data 11,22,33; after DRAIN_CYC+2 cycles frame_done=1 for one cycle and fb_bank 0->1.
// 2. B0,7F; CS high -> brightness=8'h7F one cycle after the 2nd byte; no frame_done; fb_bank unchanged.
// 3. A0,07,FE,AA,BB,CC (FB_DEPTH=2048) -> writes at 0x7FE and 0x7FF only; overflow=1; frame_done pulses; the next A0 clears overflow.
// 4. A0,00,00,55 with the last rx_valid 5 cycles after the scsn rising edge -> byte written at 0x000; frame_done fires DRAIN_CYC cycles after that byte.
// 5. Unknown opcode 3C followed by 10 bytes -> no fb_we, brightness unchanged; the next transaction parses normally.
// 6. nrst asserted in the middle of S_DATA -> all outputs 0 and no frame_done; after release, a full write transaction succeeds.

Source files
------------

// File: rtl/spi_frame_loader.sv
// rtl/spi_frame_loader.sv - SPI byte-stream parser that loads the HUB75 framebuffer
//
// Parses command-framed SPI transactions from the received-byte stream:
//   A0 <addr_h> <addr_l> <data...>  framebuffer write
//   B0 <level>                      set global brightness
// A transaction closes DRAIN_CYC cycles after chip select is released, or after the last
// late byte if that is later. A write transaction that stored at least one byte pulses
// frame_done and flips the displayed bank.
//
// Ports:
//   clk_96m    in   system clock
//   nrst       in   asynchronous active-low reset
//   rx_valid   in   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   received byte
//   spi_scsn   in   raw SPI chip select (active low, asynchronous)
//   fb_we      out  framebuffer write enable, one cycle per byte
//   fb_addr    out  framebuffer write address
//   fb_wdata   out  framebuffer write data
//   fb_bank    out  displayed bank, toggles with frame_done
//   brightness out  global brightness for the PWM stage
//   frame_done out  one-cycle pulse when a write transaction closes
//   overflow   out  sticky, data dropped beyond FB_DEPTH-1
module spi_frame_loader #(
  parameter int          ADDR_W     = 11,
  parameter int          FB_DEPTH   = 2048,
  parameter logic [7:0]  CMD_WRITE  = 8'hA0,
  parameter logic [7:0]  CMD_BRIGHT = 8'hB0,
  parameter int          DRAIN_CYC  = 16
) (
  input  logic              clk_96m,
  input  logic              nrst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              spi_scsn,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              fb_bank,
  output logic [7:0]        brightness,
  output logic              frame_done,
  output logic              overflow
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_BRIGHT, S_SKIP
  } state_t;

  state_t            state;
  logic              scsn_m, scsn_s, scsn_d;
  logic [DW-1:0]     drain_cnt;
  // One bit wider than the port so the counter can sit at FB_DEPTH without wrapping.
  logic [ADDR_W:0]   addr;
  logic [ADDR_W:0]   wr_count;
  logic              cs_rise, cs_fall, txn_end;

  assign cs_rise = scsn_s & ~scsn_d;
  assign cs_fall = ~scsn_s & scsn_d;
  // A byte arriving in the final drain cycle reloads the counter, so it still belongs to
  // this transaction and the end is pushed out.
  assign txn_end = (drain_cnt == DW'(1)) && !rx_valid && !cs_rise && !cs_fall;

  always_ff @(posedge clk_96m or negedge nrst) begin
    if (!nrst) begin
      scsn_m <= 1'b1;
      scsn_s <= 1'b1;
      scsn_d <= 1'b1;
    end else begin
      scsn_m <= spi_scsn;
      scsn_s <= scsn_m;
      scsn_d <= scsn_s;
    end
  end

  always_ff @(posedge clk_96m or negedge nrst) begin
    if (!nrst) begin
      drain_cnt <= '0;
    end else if (cs_rise) begin
      drain_cnt <= DW'(DRAIN_CYC);
    end else if (cs_fall) begin
      // CS reasserted while draining: the transaction simply continues.
      drain_cnt <= '0;
    end else if (drain_cnt != '0) begin
      drain_cnt <= rx_valid ? DW'(DRAIN_CYC) : drain_cnt - DW'(1);
    end
  end

  always_ff @(posedge clk_96m or negedge nrst) begin
    if (!nrst) begin
      state      <= S_CMD;
      addr       <= '0;
      wr_count   <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_bank    <= 1'b0;
      brightness <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (txn_end) begin
        if (state == S_DATA && wr_count != '0) begin
          frame_done <= 1'b1;
          fb_bank    <= ~fb_bank;
        end
        state <= S_CMD;
      end else if (rx_valid) begin
        case (state)
          S_CMD: begin
            if (rx_data == CMD_WRITE) begin
              state    <= S_ADDR_H;
              overflow <= 1'b0;
            end else if (rx_data == CMD_BRIGHT) begin
              state <= S_BRIGHT;
            end else begin
              state <= S_SKIP;
            end
          end
          S_ADDR_H: begin
            addr[ADDR_W]     <= 1'b0;
            addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
            state            <= S_ADDR_L;
          end
          S_ADDR_L: begin
            addr[7:0] <= rx_data;
            wr_count  <= '0;
            state     <= S_DATA;
          end
          S_DATA: begin
            if (addr < (ADDR_W+1)'(FB_DEPTH)) begin
              fb_we    <= 1'b1;
              fb_addr  <= addr[ADDR_W-1:0];
              fb_wdata <= rx_data;
              addr     <= addr + (ADDR_W+1)'(1);
              wr_count <= wr_count + (ADDR_W+1)'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
          S_BRIGHT: begin
            brightness <= rx_data;
            state      <= S_SKIP;
          end
          default: state <= S_SKIP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// tb/tb_spi_frame_loader.sv - self-checking bench for spi_frame_loader
module tb_spi_frame_loader;

  localparam int DRAIN = 16;
  typedef logic [7:0] bq_t[$];

  logic        clk_96m = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        spi_scsn = 1'b1;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_bank;
  logic [7:0]  brightness;
  logic        frame_done;
  logic        overflow;

  spi_frame_loader dut (
    .clk_96m(clk_96m), .nrst(nrst), .rx_valid(rx_valid), .rx_data(rx_data),
    .spi_scsn(spi_scsn), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_bank(fb_bank), .brightness(brightness), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk_96m = ~clk_96m;

  int cyc = 0;
  always @(posedge clk_96m) cyc <= cyc + 1;

  int got_wr[$];
  int got_wr_cyc[$];
  int got_fd[$];
  always @(negedge clk_96m) begin
    if (fb_we) begin
      got_wr.push_back((int'(fb_addr) << 8) | int'(fb_wdata));
      got_wr_cyc.push_back(cyc);
    end
    if (frame_done) got_fd.push_back(cyc);
  end

  int         checks = 0;
  int         errors = 0;
  int         exp_wr[$];
  bit         exp_ovf = 1'b0;
  bit         exp_pulse = 1'b0;
  bit         exp_bank = 1'b0;
  logic [7:0] exp_bright = 8'h00;
  int         rise_cyc = 0;
  int         sent_cyc[$];

  // Reference: decode a whole transaction from its byte list.
  task automatic model(input bq_t b);
    int a;
    exp_wr.delete();
    exp_pulse = 1'b0;
    if (b.size() == 0) return;
    if (b[0] == 8'hA0) begin
      exp_ovf = 1'b0;
      if (b.size() >= 3) begin
        a = ((int'(b[1]) & 7) * 256) + int'(b[2]);
        for (int i = 3; i < b.size(); i++) begin
          if (a < 2048) begin
            exp_wr.push_back(a * 256 + int'(b[i]));
            a++;
            exp_pulse = 1'b1;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end else if (b[0] == 8'hB0 && b.size() >= 2) begin
      exp_bright = b[1];
    end
    if (exp_pulse) exp_bank = ~exp_bank;
  endtask

  function automatic int exp_fd_cyc();
    int r, l;
    r = rise_cyc + DRAIN + 3;
    l = (sent_cyc.size() > 0) ? sent_cyc[sent_cyc.size()-1] + DRAIN + 1 : 0;
    return (l > r) ? l : r;
  endfunction

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    sent_cyc.push_back(cyc);
    @(negedge clk_96m);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk_96m);
  endtask

  task automatic clear_obs();
    got_wr.delete();
    got_wr_cyc.delete();
    got_fd.delete();
    sent_cyc.delete();
  endtask

  task automatic run_txn(input bq_t b, input int late, input int max_gap);
    clear_obs();
    spi_scsn = 1'b0;
    repeat (3) @(negedge clk_96m);
    for (int i = 0; i < b.size(); i++) begin
      if (late > 0 && i == b.size() - 1) begin
        spi_scsn = 1'b1;
        rise_cyc = cyc;
        repeat (late) @(negedge clk_96m);
      end
      send(b[i], $urandom_range(0, max_gap));
    end
    if (late == 0) begin
      spi_scsn = 1'b1;
      rise_cyc = cyc;
    end
    repeat (DRAIN + 10) @(negedge clk_96m);
  endtask

  task automatic test_reset();
    checks++;
    if ({fb_we, fb_addr, fb_wdata, fb_bank, brightness, frame_done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h bank=%b bright=%h fd=%b ovf=%b, need all 0",
               fb_we, fb_addr, fb_wdata, fb_bank, brightness, frame_done, overflow);
    end
  endtask

  task automatic test_write();
    bq_t b = '{8'hA0, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
    model(b);
    run_txn(b, 0, 0);
    checks++;
    if (got_wr.size() != 3 || got_wr[0] != 'h1011 || got_wr[1] != 'h1122 || got_wr[2] != 'h1233) begin
      errors++;
      $display("FAIL write_basic: got %0d writes first=%h, need 3 writes 010:11 011:22 012:33",
               got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : -1);
    end
    checks++;
    if (got_wr_cyc.size() != 3 || got_wr_cyc[0] != sent_cyc[3] + 1 || got_wr_cyc[2] != sent_cyc[5] + 1) begin
      errors++;
      $display("FAIL write_latency: got %0d writes, need each one cycle after its byte", got_wr_cyc.size());
    end
    checks++;
    if (got_fd.size() != 1 || got_fd[0] != rise_cyc + DRAIN + 3) begin
      errors++;
      $display("FAIL write_frame_done: got %0d pulses first at %0d, need 1 at %0d",
               got_fd.size(), (got_fd.size() > 0) ? got_fd[0] : -1, rise_cyc + DRAIN + 3);
    end
    checks++;
    if (fb_bank !== 1'b1) begin
      errors++;
      $display("FAIL write_bank: got %b, need 1", fb_bank);
    end
  endtask

  task automatic test_brightness();
    logic bank0;
    bank0 = fb_bank;
    clear_obs();
    exp_bright = 8'h7F;
    spi_scsn = 1'b0;
    repeat (3) @(negedge clk_96m);
    send(8'hB0, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h7F;
    @(negedge clk_96m);
    rx_valid = 1'b0;
    checks++;
    if (brightness !== 8'h7F) begin
      errors++;
      $display("FAIL bright_latency: got %h one cycle after byte, need 7f", brightness);
    end
    spi_scsn = 1'b1;
    repeat (DRAIN + 10) @(negedge clk_96m);
    checks++;
    if (got_fd.size() != 0 || fb_bank !== bank0 || got_wr.size() != 0) begin
      errors++;
      $display("FAIL bright_side_effects: got %0d pulses bank=%b %0d writes, need 0 pulses bank=%b 0 writes",
               got_fd.size(), fb_bank, got_wr.size(), bank0);
    end
  endtask

  task automatic test_overflow();
    bq_t b  = '{8'hA0, 8'h07, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    bq_t b2 = '{8'hA0, 8'h00, 8'h00};
    model(b);
    run_txn(b, 0, 1);
    checks++;
    if (got_wr.size() != 2 || got_wr[0] != 'h7FEAA || got_wr[1] != 'h7FFBB) begin
      errors++;
      $display("FAIL ovf_writes: got %0d writes, need 7fe:aa 7ff:bb only", got_wr.size());
    end
    checks++;
    if (overflow !== 1'b1 || got_fd.size() != 1 || fb_bank !== exp_bank) begin
      errors++;
      $display("FAIL ovf_flags: got ovf=%b pulses=%0d bank=%b, need ovf=1 pulses=1 bank=%b",
               overflow, got_fd.size(), fb_bank, exp_bank);
    end
    model(b2);
    run_txn(b2, 0, 0);
    checks++;
    if (overflow !== 1'b0 || got_fd.size() != 0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b pulses=%0d, need ovf=0 pulses=0", overflow, got_fd.size());
    end
  endtask

  task automatic test_late_byte();
    bq_t b = '{8'hA0, 8'h00, 8'h00, 8'h55};
    model(b);
    run_txn(b, 5, 0);
    checks++;
    if (got_wr.size() != 1 || got_wr[0] != 'h00055) begin
      errors++;
      $display("FAIL late_write: got %0d writes, need 000:55", got_wr.size());
    end
    checks++;
    if (got_fd.size() != 1 || got_fd[0] != sent_cyc[3] + DRAIN + 1) begin
      errors++;
      $display("FAIL late_frame_done: got %0d pulses first at %0d, need 1 at %0d",
               got_fd.size(), (got_fd.size() > 0) ? got_fd[0] : -1, sent_cyc[3] + DRAIN + 1);
    end
  endtask

  task automatic test_skip();
    bq_t b;
    logic [7:0] br0;
    br0 = brightness;
    b.push_back(8'h3C);
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom_range(0, 255)));
    model(b);
    run_txn(b, 0, 1);
    checks++;
    if (got_wr.size() != 0 || brightness !== br0 || got_fd.size() != 0) begin
      errors++;
      $display("FAIL skip_ignored: got %0d writes bright=%h pulses=%0d, need 0 writes bright=%h 0 pulses",
               got_wr.size(), brightness, got_fd.size(), br0);
    end
  endtask

  task automatic test_abort_drain();
    bq_t b = '{8'hA0, 8'h03, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
    model(b);
    clear_obs();
    spi_scsn = 1'b0;
    repeat (3) @(negedge clk_96m);
    for (int i = 0; i < 5; i++) send(b[i], 0);
    spi_scsn = 1'b1;
    repeat (8) @(negedge clk_96m);
    spi_scsn = 1'b0;
    repeat (3) @(negedge clk_96m);
    send(b[5], 0);
    send(b[6], 0);
    spi_scsn = 1'b1;
    rise_cyc = cyc;
    repeat (DRAIN + 10) @(negedge clk_96m);
    checks++;
    if (got_wr.size() != 4 || got_wr[3] != 'h32304) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes, need 4 ending 323:04", got_wr.size());
    end
    checks++;
    if (got_fd.size() != 1 || got_fd[0] != exp_fd_cyc()) begin
      errors++;
      $display("FAIL abort_frame_done: got %0d pulses first at %0d, need 1 at %0d",
               got_fd.size(), (got_fd.size() > 0) ? got_fd[0] : -1, exp_fd_cyc());
    end
  endtask

  task automatic test_random();
    bq_t b;
    int  n;
    int  sel;
    for (int t = 0; t < 8; t++) begin
      b.delete();
      sel = $urandom_range(0, 3);
      if (sel <= 1) begin
        b.push_back(8'hA0);
        if ($urandom_range(0, 1) == 1) begin
          b.push_back(8'h07);
          b.push_back(8'($urandom_range(8'hF8, 8'hFF)));
        end else begin
          b.push_back(8'($urandom_range(0, 255)));
          b.push_back(8'($urandom_range(0, 255)));
        end
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
      end else if (sel == 2) begin
        b.push_back(8'hB0);
        b.push_back(8'($urandom_range(0, 255)));
      end else begin
        b.push_back(8'($urandom_range(0, 255)));
        if (b[0] == 8'hA0 || b[0] == 8'hB0) b[0] = 8'h3C;
        b.push_back(8'($urandom_range(0, 255)));
      end
      model(b);
      run_txn(b, (t % 3 == 2) ? $urandom_range(1, 12) : 0, 2);
      checks++;
      if (got_wr != exp_wr) begin
        errors++;
        $display("FAIL rand_writes[%0d]: got %0d writes, need %0d", t, got_wr.size(), exp_wr.size());
      end
      checks++;
      if (got_fd.size() != int'(exp_pulse) || (exp_pulse && got_fd[0] != exp_fd_cyc())) begin
        errors++;
        $display("FAIL rand_frame_done[%0d]: got %0d pulses, need %0d at %0d",
                 t, got_fd.size(), exp_pulse, exp_fd_cyc());
      end
      checks++;
      if (overflow !== exp_ovf || brightness !== exp_bright || fb_bank !== exp_bank) begin
        errors++;
        $display("FAIL rand_state[%0d]: got ovf=%b bright=%h bank=%b, need ovf=%b bright=%h bank=%b",
                 t, overflow, brightness, fb_bank, exp_ovf, exp_bright, exp_bank);
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t b  = '{8'hA0, 8'h01, 8'h00};
    bq_t b2 = '{8'hA0, 8'h02, 8'h40, 8'h9A, 8'h9B};
    clear_obs();
    spi_scsn = 1'b0;
    repeat (3) @(negedge clk_96m);
    for (int i = 0; i < 3; i++) send(b[i], 0);
    send(8'h5A, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h5B;
    #2 nrst = 1'b0;
    @(negedge clk_96m);
    rx_valid = 1'b0;
    spi_scsn = 1'b1;
    checks++;
    if ({fb_we, fb_addr, fb_wdata, fb_bank, brightness, frame_done, overflow} !== '0 || got_wr.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%b bank=%b bright=%h ovf=%b writes=%0d, need all 0 and 1 write",
               fb_we, fb_bank, brightness, overflow, got_wr.size());
    end
    repeat (3) @(negedge clk_96m);
    nrst = 1'b1;
    exp_bank = 1'b0;
    exp_bright = 8'h00;
    exp_ovf = 1'b0;
    repeat (DRAIN + 10) @(negedge clk_96m);
    checks++;
    if (got_fd.size() != 0 || fb_bank !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses bank=%b, need 0 and 0", got_fd.size(), fb_bank);
    end
    model(b2);
    run_txn(b2, 0, 1);
    checks++;
    if (got_wr != exp_wr || got_fd.size() != 1 || fb_bank !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recover: got %0d writes %0d pulses bank=%b, need 2 writes 1 pulse bank=1",
               got_wr.size(), got_fd.size(), fb_bank);
    end
  endtask

  initial begin
    nrst = 1'b0;
    repeat (3) @(negedge clk_96m);
    test_reset();
    nrst = 1'b1;
    repeat (3) @(negedge clk_96m);
    test_reset();
    test_write();
    test_brightness();
    test_overflow();
    test_late_byte();
    test_skip();
    test_abort_drain();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
